// File: rtl/controlador_multiplicador.sv
// Sequencer for the shift-add multiplier datapath: start/done handshake, operand
// capture, per-bit CHECK/ADD/SHIFT/DECR/TEST stepping and product capture.
module controlador_multiplicador #(
  parameter int unsigned ANCHO = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 Inicio,
  input  logic [ANCHO-1:0]     Multiplicador_in,
  input  logic [ANCHO-1:0]     Multiplicando_in,
  input  logic                 Ack,
  input  logic                 Q_Cero,
  input  logic                 Zero,
  input  logic [2*ANCHO:0]     Producto,
  output logic                 Load_regs,
  output logic                 Shift_regs,
  output logic                 Add_regs,
  output logic                 Decr_P,
  output logic [ANCHO-1:0]     Multiplicador,
  output logic [ANCHO-1:0]     Multiplicando,
  output logic [2*ANCHO:0]     Resultado,
  output logic                 Ocupado,
  output logic                 Listo
);

  typedef enum logic [3:0] {
    StIdle,
    StLoad,
    StCheck,
    StAdd,
    StShift,
    StDecr,
    StTest,
    StCapture,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [ANCHO-1:0] multiplicador_q, multiplicador_d;
  logic [ANCHO-1:0] multiplicando_q, multiplicando_d;
  logic [2*ANCHO:0] resultado_q, resultado_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= StIdle;
      multiplicador_q <= '0;
      multiplicando_q <= '0;
      resultado_q     <= '0;
    end else begin
      state_q         <= state_d;
      multiplicador_q <= multiplicador_d;
      multiplicando_q <= multiplicando_d;
      resultado_q     <= resultado_d;
    end
  end

  // Strobes are decoded from state_q only, so no input reaches an output combinationally.
  always_comb begin
    state_d         = state_q;
    multiplicador_d = multiplicador_q;
    multiplicando_d = multiplicando_q;
    resultado_d     = resultado_q;
    Load_regs       = 1'b0;
    Shift_regs      = 1'b0;
    Add_regs        = 1'b0;
    Decr_P          = 1'b0;
    case (state_q)
      StIdle: begin
        if (Inicio) begin
          multiplicador_d = Multiplicador_in;
          multiplicando_d = Multiplicando_in;
          state_d         = StLoad;
        end
      end
      StLoad: begin
        Load_regs = 1'b1;
        state_d   = StCheck;
      end
      StCheck: state_d = Q_Cero ? StAdd : StShift;
      StAdd: begin
        Add_regs = 1'b1;
        state_d  = StShift;
      end
      StShift: begin
        Shift_regs = 1'b1;
        state_d    = StDecr;
      end
      StDecr: begin
        Decr_P  = 1'b1;
        state_d = StTest;
      end
      // Extra cycle so the datapath's Zero reflects the decremented counter.
      StTest: state_d = Zero ? StCapture : StCheck;
      StCapture: begin
        resultado_d = Producto;
        state_d     = StDone;
      end
      StDone: begin
        if (Ack) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign Multiplicador = multiplicador_q;
  assign Multiplicando = multiplicando_q;
  assign Resultado     = resultado_q;
  assign Ocupado       = (state_q != StIdle);
  assign Listo         = (state_q == StDone);

endmodule

// File: doc/controlador_multiplicador.md
# controlador_multiplicador

Control unit for the shift-add multiplier: it accepts an operand pair through a start/done handshake and sequences the `Datapath` block through load, conditional add, shift and decrement steps. It captures `Producto` into a held result register when the multiplication finishes. It sits directly upstream of `Datapath`: it drives every control strobe and operand input of that block and consumes its `Q_Cero`, `Zero` and `Producto` outputs.

## Interface
- `ANCHO`, 8, operand width; must match the `Datapath` instance.
- `clk`  in  1  system clock; all logic is rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `Inicio`  in  1  start request; sampled only in IDLE.
- `Multiplicador_in`  in  ANCHO  multiplier operand, captured on start acceptance.
- `Multiplicando_in`  in  ANCHO  multiplicand operand, captured on start acceptance.
- `Ack`  in  1  consumer acknowledge of `Resultado`; sampled only in DONE.
- `Q_Cero`  in  1  LSB of the datapath multiplier register.
- `Zero`  in  1  datapath bit-counter P has reached zero.
- `Producto`  in  2*ANCHO+1  datapath product.
- `Load_regs`, `Shift_regs`, `Add_regs`, `Decr_P`  out  1 each  one-hot datapath strobes.
- `Multiplicador`, `Multiplicando`  out  ANCHO each  registered operands to the datapath.
- `Resultado`  out  2*ANCHO+1  captured product, held until the next capture.
- `Ocupado`  out  1  high in every state except IDLE.
- `Listo`  out  1  result valid; high only in DONE.

## Operation
- States: IDLE, LOAD, CHECK, ADD, SHIFT, DECR, TEST, CAPTURE, DONE.
- All outputs are registered or Moore-decoded from the state; no combinational path runs from any input to any output.
- IDLE:
  - With `Inicio`=1, latch both operands and go to LOAD.
  - Otherwise stay in IDLE.
- LOAD: `Load_regs`=1 for one cycle, then go to CHECK. The datapath loads A=0, Q=multiplier, M=multiplicand and P=ANCHO.
- CHECK: no strobe. If `Q_Cero`=1, go to ADD; otherwise go to SHIFT.
- ADD: `Add_regs`=1, then go to SHIFT.
- SHIFT: `Shift_regs`=1, then go to DECR.
- DECR: `Decr_P`=1, then go to TEST.
- TEST: no strobe; this cycle lets the registered `Zero` settle. If `Zero`=1, go to CAPTURE; otherwise go to CHECK.
- CAPTURE: `Resultado` <= `Producto`, then go to DONE.
- DONE:
  - `Listo`=1 is held until `Ack`=1, then go to IDLE.
  - `Inicio` is ignored in DONE.
- At most one of the four strobes is high in any cycle.
- `Inicio` while `Ocupado`=1 is ignored. It is not queued and does not disturb the latched operands.
- Multiplication is unsigned: `Resultado` = `Multiplicador_in` × `Multiplicando_in`, zero-extended to 2*ANCHO+1 bits.
- An unreachable state encoding returns to IDLE on the next edge with all strobes low.

## Timing
- Reset:
  - State is IDLE.
  - All strobes, `Ocupado` and `Listo` are 0.
  - `Resultado`, `Multiplicador` and `Multiplicando` are 0.
- Reset asserted mid-operation aborts on that edge with no strobe issued afterwards. `Resultado` is cleared to 0.
- Start is accepted on edge 0 (IDLE with `Inicio`=1). Cycle 1 is LOAD. `Ocupado` rises in cycle 1.
- Each multiplier bit costs 4 cycles (CHECK, SHIFT, DECR, TEST), plus 1 cycle (ADD) when its bit is 1.
- Let k be the popcount of the multiplier. Then:
  - Bit processing spans cycles 2 to 1+4·ANCHO+k.
  - CAPTURE occurs in cycle 2+4·ANCHO+k.
  - `Listo` is high from cycle 3+4·ANCHO+k.
- With ANCHO=8: the minimum latency to `Listo` is 35 cycles (multiplier 0) and the maximum is 43 cycles (multiplier 0xFF).
- `Ack` in DONE gives IDLE the next cycle. `Listo` and `Ocupado` fall together.
- A new `Inicio` is accepted at the earliest one cycle after the `Ack` cycle.
- `Ack` and `Inicio` high together in DONE: only `Ack` acts. If `Inicio` is still high in the following IDLE cycle, it is accepted then.
- `Ack` outside DONE has no effect.

## Test plan
- Reset release, then 5 idle cycles:
  - All outputs stay 0.
  - A single-cycle `rst` pulse mid-run forces IDLE and `Resultado`=0.
- Basic product: `Multiplicador_in`=0x17, `Multiplicando_in`=0xD7, `Inicio` pulse.
  - Strobe sequence starts L, C, A, S, D, T.
  - `Listo` rises 39 cycles after acceptance.
  - `Resultado`=0x01351.
- Edge operands, with `Listo` arriving after 35 cycles for a 0 multiplier and 43 cycles for 0xFF:
  - 0×0xFF gives 0.
  - 0xFF×0xFF gives 0x0FE01.
  - 0xFF×0 gives 0.
- Handshake:
  - Hold `Ack`=0 for 20 cycles: `Listo` and `Resultado` stay stable.
  - `Inicio` pulses while `Ocupado`=1 are ignored, and the operands stay unchanged.
- Back-to-back: hold `Inicio`=1 continuously and `Ack` the first result.
  - The second operation is accepted exactly one cycle after the `Ack` cycle.
  - Both results are correct.
- Strobe checker over 200 random operand pairs run against the real `Datapath`:
  - Strobes are never overlapping.
  - Every `Resultado` equals the reference product.
